// File: rtl/prg_cache_pkg.sv
// Shared configuration, address field split and FSM encoding for the program cache.
package prg_cache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LINES      = 64;

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_REFILL = 2'd2
  } state_e;

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

endpackage

// File: rtl/prg_cache_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port whose output register resets.
module prg_cache_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prg_cache.sv
// Direct-mapped read-only program cache with line fill over a req/ack word interface.
module prg_cache
  import prg_cache_pkg::*;
#(
  parameter int unsigned ADDR_W     = prg_cache_pkg::ADDR_W,
  parameter int unsigned DATA_W     = prg_cache_pkg::DATA_W,
  parameter int unsigned LINE_WORDS = prg_cache_pkg::LINE_WORDS,
  parameter int unsigned LINES      = prg_cache_pkg::LINES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] prg_address,
  input  logic              flush,
  output logic [DATA_W-1:0] instruction,
  output logic              p_cache_miss,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned LINE_AW = IDX_W + OFF_W;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q;
  logic                     started_q;
  logic [LINES-1:0]         valid_q, valid_d;
  logic [ADDR_W-OFF_W-1:0]  fill_line_q, fill_line_d;
  logic [OFF_W-1:0]         cnt_q, cnt_d;
  logic                     flush_pend_q, flush_pend_d;

  logic [TAG_W-1:0]         tag_rd;
  logic [IDX_W-1:0]         fill_idx_c;
  logic [TAG_W-1:0]         fill_tag_c;
  logic                     hit_c;
  logic                     data_we_c;
  logic                     tag_we_c;
  logic [LINE_AW-1:0]       data_raddr_c;
  logic [LINE_AW-1:0]       data_waddr_c;

  assign fill_idx_c   = fill_line_q[IDX_W-1:0];
  assign fill_tag_c   = fill_line_q[ADDR_W-OFF_W-1 -: TAG_W];
  assign data_raddr_c = {addr_idx(prg_address), addr_off(prg_address)};
  assign data_waddr_c = {fill_idx_c, cnt_q};

  prg_cache_ram #(
    .WIDTH (DATA_W),
    .DEPTH (LINES * LINE_WORDS)
  ) u_data_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (data_we_c),
    .waddr_i (data_waddr_c),
    .wdata_i (mem_rdata),
    .raddr_i (data_raddr_c),
    .rdata_o (instruction)
  );

  prg_cache_ram #(
    .WIDTH (TAG_W),
    .DEPTH (LINES)
  ) u_tag_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (tag_we_c),
    .waddr_i (fill_idx_c),
    .wdata_i (fill_tag_c),
    .raddr_i (addr_idx(prg_address)),
    .rdata_o (tag_rd)
  );

  // Lookup result for the address registered at the previous edge.
  assign hit_c        = started_q & valid_q[addr_idx(addr_q)] & (tag_rd == addr_tag(addr_q));
  assign p_cache_miss = started_q & ((state_q != ST_IDLE) | ~hit_c);
  assign mem_req      = (state_q == ST_FILL);
  assign mem_addr     = {fill_line_q, cnt_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      started_q    <= 1'b0;
      valid_q      <= '0;
      fill_line_q  <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= prg_address;
      started_q    <= 1'b1;
      valid_q      <= valid_d;
      fill_line_q  <= fill_line_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    fill_line_d  = fill_line_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    data_we_c    = 1'b0;
    tag_we_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          valid_d = '0;
        end
        if (started_q && !hit_c) begin
          fill_line_d = addr_q[ADDR_W-1:OFF_W];
          cnt_d       = '0;
          state_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        if (flush) begin
          flush_pend_d = 1'b1;
        end
        if (mem_ack) begin
          data_we_c = 1'b1;
          cnt_d     = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            tag_we_c            = 1'b1;
            valid_d[fill_idx_c] = 1'b1;
            state_d             = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        // A flush deferred during the fill also drops the line just written.
        if (flush || flush_pend_q) begin
          valid_d = '0;
        end
        flush_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
